amds_frame_rx: RTL and testbench
================================

# amds_frame_rx

Parametrised successor to the fixed four-channel AMDS ADC receiver. Receives one framed burst of NUM_CH ADC samples over a single 8N1 UART line from the AMDS after each trigger. Stages every sample and commits it atomically to the per-channel output registers. Keeps valid, corrupt, timeout, header-mismatch and overrun statistics, and sits between the timing manager's trigger and the AXI register file of the AMDS IP.

## Interface

**Parameters**
- `NUM_CH`, default 4: channels per frame, 1..16.
- `HDR_NIBBLE`, default 4'h9: required upper nibble of every header byte.
- `CLKS_PER_BIT`, default 20: clk cycles per UART bit, minimum 4.
- `TIMEOUT_CLKS`, default 2000: clk cycles allowed from receiver arm to start-bit edge.

**Ports**
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start_rx`, in, 1: one-cycle trigger requesting a frame.
- `din`, in, 1: asynchronous UART line from the AMDS; idles high.
- `adc_uart_done`, out, 1: high when no frame is in progress.
- `is_dout_valid`, out, NUM_CH: bit k high means channel k holds a sample from the current frame.
- `adc_dout`, out, 16*NUM_CH: channel k occupies bits [16k+15:16k].
- `counter_data_valid`, out, 16: count of good bytes received.
- `counter_data_corrupt`, out, 16: count of bad stop bits and checksum failures.
- `counter_data_timeout`, out, 16: count of start-bit timeouts.
- `counter_hdr_mismatch`, out, 16: count of bad header bytes.
- `counter_overrun`, out, 16: count of `start_rx` pulses received while busy.

## Operation

**Frame format**
- Per channel k = 0..NUM_CH-1: header byte {HDR_NIBBLE, k[3:0]}, then data MSB, then data LSB.
- With checksum enabled, a fourth byte follows each packet (see Configuration).

**Byte receiver**
- `din` passes through a 2-flop synchroniser.
- Each arm starts a TIMEOUT_CLKS window; a falling edge inside the window starts a byte.
- Bits are sampled at mid-bit, LSB first. The stop bit must be 1.
- Result is a one-cycle pulse: `byte_valid`, `corrupt` (stop bit 0), or `timeout`.

**FSM states**
- IDLE: on `start_rx` clear all `is_dout_valid`, drop done, reset channel index to 0, arm the receiver, go to HDR.
- HDR: if the byte equals the expected header, go to MSB and re-arm. On a header mismatch, increment `counter_hdr_mismatch` and abort.
- MSB / LSB: load the byte into the staging register, then re-arm (MSB) or go to CHK/COMMIT (LSB).
- CHK (checksum build only): compare the received byte with the running checksum; on mismatch increment `counter_data_corrupt` and abort.
- COMMIT: copy staging into channel k, set `is_dout_valid[k]`. If k == NUM_CH-1, set done and go to IDLE; otherwise increment k, re-arm, go to HDR.
- Abort: set done, go to IDLE. Already-committed channels keep their valid bits.

**Rules**
- `counter_data_valid` increments on every byte_valid that the FSM accepts, headers included.
- A receiver `corrupt` or `timeout` pulse in any receiving state increments the matching counter and aborts.
- Every counter wraps 0xFFFF to 0x0000.
- `adc_dout` only changes in COMMIT, so an aborted channel keeps its previous sample (with valid low). A torn sample is never visible.
- `start_rx` while not in IDLE is ignored and increments `counter_overrun`.

## Timing

- Reset values: `adc_uart_done` = 1; `is_dout_valid`, `adc_dout` and all counters = 0; FSM in IDLE; receiver disarmed.
- Done falls at the edge after `start_rx` is sampled in IDLE.
- Last byte pulse at cycle T: FSM is in COMMIT at T+1. Data, valid[k] and done all update together at the T+2 edge.
- Abort: done = 1 at the edge following the error pulse.
- Receiver re-arm happens in the same cycle as the accepting byte pulse, so there is no lost start edge for back-to-back bytes.
- The synchroniser adds 2 cycles of latency from `din` to sampling.
- Reset asserted mid-frame returns everything to reset values immediately. After reset releases, the line must be idle high before the next arm.

## Configuration

- `AMDS_CHECKSUM_EN` defined:
  - Each packet carries a fourth byte equal to header XOR MSB XOR LSB.
  - The CHK state exists and a mismatch counts as corrupt.
- Not defined: packets are 3 bytes, the CHK state is absent, and LSB goes straight to COMMIT.

## Structure

- Package `amds_pkg` holds:
  - FSM state enum;
  - default header nibble constant;
  - counter width constant (16);
  - byte-receiver result encoding.
- One sub-module, `amds_uart_byte_rx`: synchroniser, bit timing, timeout, and the byte / corrupt / timeout pulses. The frame FSM, staging, checksum and counters stay in the top level.

## Test plan

- NUM_CH = 4, clean frame with samples 0x1234/0xABCD/0x0001/0xFFFF: outputs match, `is_dout_valid` = 4'hF, `counter_data_valid` += 12, done returns 1.
- Channel 2 header sent as 0x93: `counter_hdr_mismatch` = 1, `is_dout_valid` = 4'b0011, channel 2 output unchanged, done = 1.
- Line held high after the trigger: `counter_data_timeout` = 1 after TIMEOUT_CLKS+3 cycles, done = 1, valid = 0.
- Stop bit forced to 0 on an MSB byte: `counter_data_corrupt` = 1 and abort. With `AMDS_CHECKSUM_EN`, a wrong checksum byte gives the same result.
- `start_rx` pulsed mid-frame: `counter_overrun` = 1 and the frame completes normally. Preload a counter to 0xFFFF and it wraps to 0.
- `rst` pulsed mid-LSB: all outputs return to reset values the same cycle, and the following clean frame is received correctly.

Source files
------------

// File: rtl/amds_pkg.sv
// Shared types and constants for the AMDS frame receiver.
// AMDS_CHECKSUM_EN adds the checksum state to the frame FSM encoding.
package amds_pkg;

  localparam int CNT_W = 16;
  localparam logic [3:0] HDR_NIBBLE_DEF = 4'h9;

  typedef enum logic [1:0] {
    RX_NONE,
    RX_BYTE,
    RX_CORRUPT,
    RX_TIMEOUT
  } rx_res_e;

  typedef enum logic [2:0] {
    R_OFF,
    R_WAIT,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

`ifdef AMDS_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_MSB,
    S_LSB,
    S_CHK,
    S_COMMIT
  } frame_state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_MSB,
    S_LSB,
    S_COMMIT
  } frame_state_e;
`endif

  function automatic logic [7:0] hdr_byte(input logic [3:0] nib, input logic [3:0] ch);
    return {nib, ch};
  endfunction

endpackage

// File: rtl/amds_frame_rx_if.sv
// Trigger, UART line and result/statistics bundle of the AMDS frame receiver.
interface amds_frame_rx_if
  import amds_pkg::*;
#(
  parameter int NUM_CH = 4
);
  logic                  start_rx;
  logic                  din;
  logic                  adc_uart_done;
  logic [NUM_CH-1:0]     is_dout_valid;
  logic [16*NUM_CH-1:0]  adc_dout;
  logic [CNT_W-1:0]      counter_data_valid;
  logic [CNT_W-1:0]      counter_data_corrupt;
  logic [CNT_W-1:0]      counter_data_timeout;
  logic [CNT_W-1:0]      counter_hdr_mismatch;
  logic [CNT_W-1:0]      counter_overrun;

  modport master (
    output start_rx, din,
    input  adc_uart_done, is_dout_valid, adc_dout,
    input  counter_data_valid, counter_data_corrupt, counter_data_timeout,
    input  counter_hdr_mismatch, counter_overrun
  );

  modport slave (
    input  start_rx, din,
    output adc_uart_done, is_dout_valid, adc_dout,
    output counter_data_valid, counter_data_corrupt, counter_data_timeout,
    output counter_hdr_mismatch, counter_overrun
  );
endinterface

// File: rtl/amds_uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, arm-to-start timeout.
// Emits a one-cycle byte / corrupt / timeout result, then stays idle until re-armed.
module amds_uart_byte_rx
  import amds_pkg::*;
#(
  parameter int CLKS_PER_BIT = 20,
  parameter int TIMEOUT_CLKS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm_i,
  input  logic       din_i,
  output rx_res_e    res_o,
  output logic [7:0] data_o
);

  localparam int BW   = $clog2(CLKS_PER_BIT);
  localparam int TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  rx_state_e      state_q, state_d;
  logic [1:0]     sync_q;
  logic           prev_q;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  rx_res_e        res_q, res_d;
  logic           din_s;
  logic           fall;

  assign din_s = sync_q[1];
  assign fall  = prev_q & ~din_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= R_OFF;
      sync_q    <= 2'b11;
      prev_q    <= 1'b1;
      bit_cnt_q <= '0;
      tmo_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      res_q     <= RX_NONE;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], din_i};
      prev_q    <= din_s;
      bit_cnt_q <= bit_cnt_d;
      tmo_q     <= tmo_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      res_q     <= res_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    tmo_d     = tmo_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    res_d     = RX_NONE;
    case (state_q)
      R_WAIT: begin
        if (fall) begin
          state_d   = R_START;
          bit_cnt_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CLKS - 1)) begin
          res_d   = RX_TIMEOUT;
          state_d = R_OFF;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      R_START: begin
        // A start bit that is high again at its centre was a glitch; keep waiting.
        if (bit_cnt_q == BW'(HALF - 1)) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = din_s ? R_WAIT : R_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      R_DATA: begin
        if (bit_cnt_q == BW'(CLKS_PER_BIT - 1)) begin
          bit_cnt_d = '0;
          shift_d   = {din_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) state_d = R_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      R_STOP: begin
        if (bit_cnt_q == BW'(CLKS_PER_BIT - 1)) begin
          res_d   = din_s ? RX_BYTE : RX_CORRUPT;
          state_d = R_OFF;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      default: ;
    endcase
    if (arm_i) begin
      state_d = R_WAIT;
      tmo_d   = '0;
    end
  end

  assign res_o  = res_q;
  assign data_o = shift_q;

endmodule

// File: rtl/amds_frame_rx.sv
// AMDS framed ADC receiver: header/MSB/LSB per channel, atomic per-channel commit, statistics.
// Define AMDS_CHECKSUM_EN to require a header^MSB^LSB checksum byte after each packet.
module amds_frame_rx
  import amds_pkg::*;
#(
  parameter int         NUM_CH       = 4,
  parameter logic [3:0] HDR_NIBBLE   = HDR_NIBBLE_DEF,
  parameter int         CLKS_PER_BIT = 20,
  parameter int         TIMEOUT_CLKS = 2000
) (
  input logic            clk,
  input logic            rst,
  amds_frame_rx_if.slave bus
);

  frame_state_e         state_q, state_d;
  logic [3:0]           ch_q, ch_d;
  logic [15:0]          stage_q, stage_d;
  logic                 done_q, done_d;
  logic [NUM_CH-1:0]    valid_q, valid_d;
  logic [16*NUM_CH-1:0] dout_q, dout_d;
  logic [CNT_W-1:0]     cnt_valid_q, cnt_valid_d;
  logic [CNT_W-1:0]     cnt_corrupt_q, cnt_corrupt_d;
  logic [CNT_W-1:0]     cnt_timeout_q, cnt_timeout_d;
  logic [CNT_W-1:0]     cnt_hdr_q, cnt_hdr_d;
  logic [CNT_W-1:0]     cnt_ovr_q, cnt_ovr_d;
`ifdef AMDS_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif
  logic                 rx_arm;
  logic                 abort;
  rx_res_e              rx_res;
  logic [7:0]           rx_data;

  amds_uart_byte_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_byte_rx (
    .clk    (clk),
    .rst    (rst),
    .arm_i  (rx_arm),
    .din_i  (bus.din),
    .res_o  (rx_res),
    .data_o (rx_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      stage_q       <= '0;
      done_q        <= 1'b1;
      valid_q       <= '0;
      dout_q        <= '0;
      cnt_valid_q   <= '0;
      cnt_corrupt_q <= '0;
      cnt_timeout_q <= '0;
      cnt_hdr_q     <= '0;
      cnt_ovr_q     <= '0;
`ifdef AMDS_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      stage_q       <= stage_d;
      done_q        <= done_d;
      valid_q       <= valid_d;
      dout_q        <= dout_d;
      cnt_valid_q   <= cnt_valid_d;
      cnt_corrupt_q <= cnt_corrupt_d;
      cnt_timeout_q <= cnt_timeout_d;
      cnt_hdr_q     <= cnt_hdr_d;
      cnt_ovr_q     <= cnt_ovr_d;
`ifdef AMDS_CHECKSUM_EN
      csum_q        <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    stage_d       = stage_q;
    done_d        = done_q;
    valid_d       = valid_q;
    dout_d        = dout_q;
    cnt_valid_d   = cnt_valid_q;
    cnt_corrupt_d = cnt_corrupt_q;
    cnt_timeout_d = cnt_timeout_q;
    cnt_hdr_d     = cnt_hdr_q;
    cnt_ovr_d     = cnt_ovr_q;
`ifdef AMDS_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    rx_arm        = 1'b0;
    abort         = 1'b0;

    if (bus.start_rx && state_q != S_IDLE) cnt_ovr_d = cnt_ovr_q + 1'b1;

    if (state_q == S_IDLE) begin
      if (bus.start_rx) begin
        valid_d = '0;
        done_d  = 1'b0;
        ch_d    = '0;
        rx_arm  = 1'b1;
        state_d = S_HDR;
      end
    end else if (state_q == S_COMMIT) begin
      // The only place adc_dout changes, so a partially received sample is never visible.
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_q == 4'(k)) begin
          dout_d[16*k +: 16] = stage_q;
          valid_d[k]         = 1'b1;
        end
      end
      if (ch_q == 4'(NUM_CH - 1)) begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end else begin
        ch_d    = ch_q + 4'd1;
        rx_arm  = 1'b1;
        state_d = S_HDR;
      end
    end else if (rx_res == RX_CORRUPT) begin
      cnt_corrupt_d = cnt_corrupt_q + 1'b1;
      abort         = 1'b1;
    end else if (rx_res == RX_TIMEOUT) begin
      cnt_timeout_d = cnt_timeout_q + 1'b1;
      abort         = 1'b1;
    end else if (rx_res == RX_BYTE) begin
      case (state_q)
        S_HDR: begin
          if (rx_data == hdr_byte(HDR_NIBBLE, ch_q)) begin
            cnt_valid_d = cnt_valid_q + 1'b1;
            rx_arm      = 1'b1;
            state_d     = S_MSB;
`ifdef AMDS_CHECKSUM_EN
            csum_d      = rx_data;
`endif
          end else begin
            cnt_hdr_d = cnt_hdr_q + 1'b1;
            abort     = 1'b1;
          end
        end
        S_MSB: begin
          cnt_valid_d    = cnt_valid_q + 1'b1;
          stage_d[15:8]  = rx_data;
          rx_arm         = 1'b1;
          state_d        = S_LSB;
`ifdef AMDS_CHECKSUM_EN
          csum_d         = csum_q ^ rx_data;
`endif
        end
        S_LSB: begin
          cnt_valid_d   = cnt_valid_q + 1'b1;
          stage_d[7:0]  = rx_data;
`ifdef AMDS_CHECKSUM_EN
          csum_d        = csum_q ^ rx_data;
          rx_arm        = 1'b1;
          state_d       = S_CHK;
`else
          state_d       = S_COMMIT;
`endif
        end
`ifdef AMDS_CHECKSUM_EN
        S_CHK: begin
          if (rx_data == csum_q) begin
            cnt_valid_d = cnt_valid_q + 1'b1;
            state_d     = S_COMMIT;
          end else begin
            cnt_corrupt_d = cnt_corrupt_q + 1'b1;
            abort         = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end

    // Channels committed before the failure keep their valid bits.
    if (abort) begin
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end

  assign bus.adc_uart_done        = done_q;
  assign bus.is_dout_valid        = valid_q;
  assign bus.adc_dout             = dout_q;
  assign bus.counter_data_valid   = cnt_valid_q;
  assign bus.counter_data_corrupt = cnt_corrupt_q;
  assign bus.counter_data_timeout = cnt_timeout_q;
  assign bus.counter_hdr_mismatch = cnt_hdr_q;
  assign bus.counter_overrun      = cnt_ovr_q;

endmodule

// File: tb/tb_amds_frame_rx.sv
// Directed bench for amds_frame_rx: UART frame generator plus a scoreboard of committed samples.
module tb_amds_frame_rx;

  localparam int NCH = 4;
  localparam int CPB = 8;
  localparam int TMO = 200;
`ifdef AMDS_CHECKSUM_EN
  localparam int BPP = 4;
`else
  localparam int BPP = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  logic rst2;
  always #5 clk = ~clk;

  amds_frame_rx_if #(.NUM_CH(NCH)) bus ();
  amds_frame_rx_if #(.NUM_CH(1))   bus2 ();

  amds_frame_rx #(
    .NUM_CH(NCH), .HDR_NIBBLE(4'h9), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Second instance with a very long timeout, used only to walk the overrun counter through its wrap.
  amds_frame_rx #(
    .NUM_CH(1), .HDR_NIBBLE(4'h9), .CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(70000)
  ) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2)
  );

  typedef struct {
    int          ch;
    logic [15:0] val;
  } sb_t;

  sb_t         sb_q[$];
  logic [15:0] exp_dout[NCH];
  int          n_assert = 0;
  int          n_fail   = 0;
  bit          wrap_done = 1'b0;
  int          ev, ec, et, eh, eo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit pulse, input int nbits = 10);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        bus.din      = fr[i];
        bus.start_rx = pulse && (i == 1) && (c == 0);
      end
    end
  endtask

  task automatic trigger();
    @(negedge clk);
    bus.start_rx = 1'b1;
    @(negedge clk);
    bus.start_rx = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.din = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_packet(input int k, input logic [15:0] v, input logic [7:0] hdr,
                             input bit msb_stop, input bit bad_csum, input bit pulse,
                             output bit ok);
    logic [7:0] good_hdr;
    sb_t        e;
    good_hdr = {4'h9, 4'(k)};
    e.ch     = k;
    e.val    = v;
    ok       = 1'b0;
    send_byte(hdr, 1'b1, pulse);
    if (hdr != good_hdr) return;
    ev++;
    send_byte(v[15:8], msb_stop, 1'b0);
    if (!msb_stop) return;
    ev++;
`ifdef AMDS_CHECKSUM_EN
    send_byte(v[7:0], 1'b1, 1'b0);
    ev++;
    if (!bad_csum) sb_q.push_back(e);
    send_byte(hdr ^ v[15:8] ^ v[7:0] ^ {7'd0, bad_csum}, 1'b1, 1'b0);
    if (bad_csum) return;
    ev++;
`else
    if (bad_csum) return;
    sb_q.push_back(e);
    send_byte(v[7:0], 1'b1, 1'b0);
    ev++;
`endif
    ok = 1'b1;
  endtask

  task automatic send_frame(input logic [15:0] s0, input logic [15:0] s1,
                            input logic [15:0] s2, input logic [15:0] s3,
                            input int bad_hdr_ch, input int bad_msb_ch,
                            input int bad_csum_ch, input int pulse_ch);
    logic [15:0] s[NCH];
    logic [7:0]  h;
    bit          ok;
    s = '{s0, s1, s2, s3};
    trigger();
    for (int k = 0; k < NCH; k++) begin
      h = {4'h9, 4'(k)};
      if (k == bad_hdr_ch) h = h ^ 8'h01;
      send_packet(k, s[k], h, k != bad_msb_ch, k == bad_csum_ch, k == pulse_ch, ok);
      if (!ok) break;
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 100 && bus.adc_uart_done !== 1'b1; i++) @(negedge clk);
    check(tag, 64'(bus.adc_uart_done), 64'd1);
  endtask

  task automatic check_sb();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("dout_ch%0d", e.ch), 64'(bus.adc_dout[16*e.ch +: 16]), 64'(e.val));
      exp_dout[e.ch] = e.val;
    end
  endtask

  function automatic logic [63:0] exp_vec();
    logic [63:0] r;
    for (int k = 0; k < NCH; k++) r[16*k +: 16] = exp_dout[k];
    return r;
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cnt_valid"},   64'(bus.counter_data_valid),   64'(16'(ev)));
    check({tag, "_cnt_corrupt"}, 64'(bus.counter_data_corrupt), 64'(16'(ec)));
    check({tag, "_cnt_timeout"}, 64'(bus.counter_data_timeout), 64'(16'(et)));
    check({tag, "_cnt_hdr"},     64'(bus.counter_hdr_mismatch), 64'(16'(eh)));
    check({tag, "_cnt_ovr"},     64'(bus.counter_overrun),      64'(16'(eo)));
  endtask

  initial begin
    bus.start_rx = 1'b0;
    bus.din      = 1'b1;
    rst          = 1'b1;
    ev = 0; ec = 0; et = 0; eh = 0; eo = 0;
    for (int k = 0; k < NCH; k++) exp_dout[k] = 16'h0000;
    repeat (3) @(negedge clk);

    check("rst_done",  64'(bus.adc_uart_done), 64'd1);
    check("rst_valid", 64'(bus.is_dout_valid), 64'd0);
    check("rst_dout",  64'(bus.adc_dout),      64'd0);
    check_counters("rst");
    rst = 1'b0;
    idle(5);

    // Clean frame
    send_frame(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF, -1, -1, -1, -1);
    wait_done("clean_done");
    check_sb();
    check("clean_valid", 64'(bus.is_dout_valid), 64'hF);
    check_counters("clean");
    idle(10);

    // Trigger while busy is counted and otherwise ignored
    eo = 1;
    send_frame(16'h5A5A, 16'h0F0F, 16'h8000, 16'h7FFE, -1, -1, -1, 1);
    wait_done("ovr_done");
    check_sb();
    check("ovr_valid", 64'(bus.is_dout_valid), 64'hF);
    check_counters("ovr");
    idle(10);

    // Channel 2 header arrives as 0x93
    eh = 1;
    send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 2, -1, -1, -1);
    wait_done("hdr_done");
    check_sb();
    check("hdr_valid", 64'(bus.is_dout_valid), 64'h3);
    check("hdr_dout_all", 64'(bus.adc_dout), exp_vec());
    check_counters("hdr");
    idle(10);

    // Line stays idle after the trigger
    trigger();
    repeat (TMO + 3) @(negedge clk);
    et = 1;
    check("tmo_done",  64'(bus.adc_uart_done), 64'd1);
    check("tmo_valid", 64'(bus.is_dout_valid), 64'd0);
    check("tmo_dout",  64'(bus.adc_dout),      exp_vec());
    check_counters("tmo");
    idle(10);

    // Stop bit of channel 0 MSB driven low
    ec = 1;
    send_frame(16'h7777, 16'h8888, 16'h9999, 16'hAAAA, -1, 0, -1, -1);
    idle(4);
    wait_done("stop_done");
    check("stop_valid", 64'(bus.is_dout_valid), 64'd0);
    check("stop_dout",  64'(bus.adc_dout),      exp_vec());
    check_counters("stop");
    idle(10);

`ifdef AMDS_CHECKSUM_EN
    ec = 2;
    send_frame(16'h0102, 16'h0304, 16'h0506, 16'h0708, -1, -1, 1, -1);
    wait_done("csum_done");
    check_sb();
    check("csum_valid", 64'(bus.is_dout_valid), 64'h1);
    check("csum_dout",  64'(bus.adc_dout),      exp_vec());
    check_counters("csum");
    idle(10);
`endif

    // Reset in the middle of channel 0 LSB
    trigger();
    send_byte(8'h90, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b1, 1'b0);
    send_byte(8'h5A, 1'b1, 1'b0, 4);
    rst = 1'b1;
    #1;
    ev = 0; ec = 0; et = 0; eh = 0; eo = 0;
    for (int k = 0; k < NCH; k++) exp_dout[k] = 16'h0000;
    check("mrst_done",  64'(bus.adc_uart_done), 64'd1);
    check("mrst_valid", 64'(bus.is_dout_valid), 64'd0);
    check("mrst_dout",  64'(bus.adc_dout),      64'd0);
    check_counters("mrst");
    bus.din = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    idle(10);
    send_frame(16'hCAFE, 16'hBEEF, 16'h0000, 16'h8001, -1, -1, -1, -1);
    wait_done("post_done");
    check_sb();
    check("post_valid", 64'(bus.is_dout_valid), 64'hF);
    check("post_dout_all", 64'(bus.adc_dout), exp_vec());
    check_counters("post");

    for (int i = 0; i < 80000 && !wrap_done; i++) @(negedge clk);
    check("wrap_run_complete", 64'(wrap_done), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Hold the trigger high on the second instance: every cycle after the first counts an overrun.
  initial begin
    bus2.start_rx = 1'b0;
    bus2.din      = 1'b1;
    rst2          = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    @(negedge clk);
    bus2.start_rx = 1'b1;
    repeat (65536) @(negedge clk);
    check("ovr_wrap_ffff", 64'(bus2.counter_overrun), 64'hFFFF);
    @(negedge clk);
    check("ovr_wrap_zero", 64'(bus2.counter_overrun), 64'h0000);
    bus2.start_rx = 1'b0;
    wrap_done = 1'b1;
  end

endmodule
